// File: rtl/rc4_pkg.sv
// Shared types and widths for the RC4 phase sequencer and its S-memory arbiter.
package rc4_pkg;

  localparam int S_ADDR_W = 8;
  localparam int S_DATA_W = 8;
  localparam int KEY_W    = 24;

  typedef enum logic [3:0] {
    IDLE,
    INIT_RST,
    INIT_GO,
    INIT_WAIT,
    SHUF_RST,
    SHUF_GO,
    SHUF_WAIT,
    DEC_RST,
    DEC_GO,
    DEC_WAIT,
    DONE,
    FAIL
  } rc4_sched_state_t;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_INIT,
    OWN_SHUF,
    OWN_DEC
  } rc4_owner_t;

  // Each engine owns the memory for its whole RST/GO/WAIT window.
  function automatic rc4_owner_t owner_of(input rc4_sched_state_t s);
    case (s)
      INIT_RST, INIT_GO, INIT_WAIT: return OWN_INIT;
      SHUF_RST, SHUF_GO, SHUF_WAIT: return OWN_SHUF;
      DEC_RST, DEC_GO, DEC_WAIT:    return OWN_DEC;
      default:                      return OWN_NONE;
    endcase
  endfunction

endpackage

// File: rtl/rc4_sched_if.sv
// Bundle between the RC4 sequencer, the key/switch logic, the three phase engines and S-memory.
interface rc4_sched_if;
  import rc4_pkg::*;

  logic                start;
  logic [KEY_W-1:0]    key_in;
  logic [KEY_W-1:0]    key;
  logic                busy;
  logic                done;
  logic                fail;

  logic                init_rst;
  logic                shuf_rst;
  logic                dec_rst;
  logic                init_start;
  logic                shuf_start;
  logic                dec_start;
  logic                init_finish;
  logic                shuf_finish;
  logic                dec_finish;
  logic                dec_valid;

  logic [S_ADDR_W-1:0] init_addr;
  logic [S_ADDR_W-1:0] shuf_addr;
  logic [S_ADDR_W-1:0] dec_addr;
  logic [S_DATA_W-1:0] init_data;
  logic [S_DATA_W-1:0] shuf_data;
  logic [S_DATA_W-1:0] dec_data;
  logic                init_wren;
  logic                shuf_wren;
  logic                dec_wren;

  logic [S_ADDR_W-1:0] s_address;
  logic [S_DATA_W-1:0] s_data;
  logic                s_wren;
  logic [S_DATA_W-1:0] s_q;

  // The sequencer is the master; s_q bypasses it and goes straight to the engines.
  modport master (
    input  start, key_in,
    input  init_finish, shuf_finish, dec_finish, dec_valid,
    input  init_addr, shuf_addr, dec_addr,
    input  init_data, shuf_data, dec_data,
    input  init_wren, shuf_wren, dec_wren,
    output key, busy, done, fail,
    output init_rst, shuf_rst, dec_rst,
    output init_start, shuf_start, dec_start,
    output s_address, s_data, s_wren
  );

  modport slave (
    output start, key_in,
    output init_finish, shuf_finish, dec_finish, dec_valid,
    output init_addr, shuf_addr, dec_addr,
    output init_data, shuf_data, dec_data,
    output init_wren, shuf_wren, dec_wren,
    output s_q,
    input  key, busy, done, fail,
    input  init_rst, shuf_rst, dec_rst,
    input  init_start, shuf_start, dec_start,
    input  s_address, s_data, s_wren
  );

endinterface

// File: rtl/s_mem_mux.sv
// Combinational owner-select of the engine requests onto the single-port S-memory.
module s_mem_mux
  import rc4_pkg::*;
(
  input  rc4_owner_t          owner,
  input  logic [S_ADDR_W-1:0] init_addr,
  input  logic [S_DATA_W-1:0] init_data,
  input  logic                init_wren,
  input  logic [S_ADDR_W-1:0] shuf_addr,
  input  logic [S_DATA_W-1:0] shuf_data,
  input  logic                shuf_wren,
  input  logic [S_ADDR_W-1:0] dec_addr,
  input  logic [S_DATA_W-1:0] dec_data,
  input  logic                dec_wren,
  output logic [S_ADDR_W-1:0] s_address,
  output logic [S_DATA_W-1:0] s_data,
  output logic                s_wren
);

  // With no owner the memory sees a quiet bus, so a stray engine write can never land.
  always_comb begin
    s_address = '0;
    s_data    = '0;
    s_wren    = 1'b0;
    case (owner)
      OWN_INIT: begin
        s_address = init_addr;
        s_data    = init_data;
        s_wren    = init_wren;
      end
      OWN_SHUF: begin
        s_address = shuf_addr;
        s_data    = shuf_data;
        s_wren    = shuf_wren;
      end
      OWN_DEC: begin
        s_address = dec_addr;
        s_data    = dec_data;
        s_wren    = dec_wren;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/rc4_sched.sv
// RC4 phase sequencer: runs init -> shuffle -> decrypt and arbitrates S-memory.
// Optional key sweep over the low KEY_BITS of the secret is enabled with RC4_KEY_SWEEP_EN.
module rc4_sched
  import rc4_pkg::*;
#(
  parameter int KEY_BITS = 22
) (
  input logic         clk,
  input logic         rst,
  rc4_sched_if.master bus
);

  localparam logic [KEY_W-1:0] KEY_MASK = {KEY_W{1'b1}} >> (KEY_W - KEY_BITS);
  localparam logic [KEY_W-1:0] KEY_ONE  = {{(KEY_W-1){1'b0}}, 1'b1};

  rc4_sched_state_t state;
  rc4_owner_t       owner;
  logic [KEY_W-1:0] key;
  logic             busy;
  logic             done;
  logic             fail;
  logic             init_rst;
  logic             shuf_rst;
  logic             dec_rst;
  logic             init_start;
  logic             shuf_start;
  logic             dec_start;

  // Pulse outputs are set on the transition into their state, so they line up with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      key        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      fail       <= 1'b0;
      init_rst   <= 1'b0;
      shuf_rst   <= 1'b0;
      dec_rst    <= 1'b0;
      init_start <= 1'b0;
      shuf_start <= 1'b0;
      dec_start  <= 1'b0;
    end else begin
      init_rst   <= 1'b0;
      shuf_rst   <= 1'b0;
      dec_rst    <= 1'b0;
      init_start <= 1'b0;
      shuf_start <= 1'b0;
      dec_start  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            key      <= bus.key_in & KEY_MASK;
            busy     <= 1'b1;
            init_rst <= 1'b1;
            state    <= INIT_RST;
          end
        end
        INIT_RST: begin
          init_start <= 1'b1;
          state      <= INIT_GO;
        end
        INIT_GO: state <= INIT_WAIT;
        INIT_WAIT: begin
          if (bus.init_finish) begin
            shuf_rst <= 1'b1;
            state    <= SHUF_RST;
          end
        end
        SHUF_RST: begin
          shuf_start <= 1'b1;
          state      <= SHUF_GO;
        end
        SHUF_GO: state <= SHUF_WAIT;
        SHUF_WAIT: begin
          if (bus.shuf_finish) begin
            dec_rst <= 1'b1;
            state   <= DEC_RST;
          end
        end
        DEC_RST: begin
          dec_start <= 1'b1;
          state     <= DEC_GO;
        end
        DEC_GO: state <= DEC_WAIT;
        DEC_WAIT: begin
          if (bus.dec_finish) begin
            if (bus.dec_valid) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end else begin
`ifdef RC4_KEY_SWEEP_EN
              // Upper key bits stay zero, so comparing the whole key against the mask is enough.
              if (key != KEY_MASK) begin
                key      <= key + KEY_ONE;
                init_rst <= 1'b1;
                state    <= INIT_RST;
              end else begin
                busy  <= 1'b0;
                fail  <= 1'b1;
                state <= FAIL;
              end
`else
              busy  <= 1'b0;
              fail  <= 1'b1;
              state <= FAIL;
`endif
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign owner = owner_of(state);

  s_mem_mux u_mux (
    .owner     (owner),
    .init_addr (bus.init_addr),
    .init_data (bus.init_data),
    .init_wren (bus.init_wren),
    .shuf_addr (bus.shuf_addr),
    .shuf_data (bus.shuf_data),
    .shuf_wren (bus.shuf_wren),
    .dec_addr  (bus.dec_addr),
    .dec_data  (bus.dec_data),
    .dec_wren  (bus.dec_wren),
    .s_address (bus.s_address),
    .s_data    (bus.s_data),
    .s_wren    (bus.s_wren)
  );

  assign bus.key        = key;
  assign bus.busy       = busy;
  assign bus.done       = done;
  assign bus.fail       = fail;
  assign bus.init_rst   = init_rst;
  assign bus.shuf_rst   = shuf_rst;
  assign bus.dec_rst    = dec_rst;
  assign bus.init_start = init_start;
  assign bus.shuf_start = shuf_start;
  assign bus.dec_start  = dec_start;

endmodule
